// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: pulses the PLL reset, waits for a stable synchronized lock, then releases
// core and peripheral resets in two stages; lock loss drops both resets, lock timeout re-pulses the PLL.
module pll_reset_sequencer #(
   parameter int PLL_RST_CYCLES = 16,
   parameter int LOCK_TIMEOUT   = 65536,
   parameter int STABLE_CYCLES  = 1024,
   parameter int STAGE_DELAY    = 64
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       lock,
   output logic       pll_resetb,
   output logic       rst_core_n,
   output logic       rst_periph_n,
   output logic       ready,
   output logic [7:0] lock_loss_count,
   output logic [7:0] retry_count
);
   localparam int MAX_AB = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_CD = (STABLE_CYCLES > STAGE_DELAY) ? STABLE_CYCLES : STAGE_DELAY;
   localparam int MAXP   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int CW     = $clog2(MAXP + 1);

   typedef enum logic [2:0] {PLL_RST, WAIT_LOCK, STABLE, RELEASE, RUN} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    sync_q;
   logic          pll_resetb_q, pll_resetb_d;
   logic          rst_core_n_q, rst_core_n_d;
   logic          rst_periph_n_q, rst_periph_n_d;
   logic [7:0]    lock_loss_q, lock_loss_d;
   logic [7:0]    retry_q, retry_d;
   logic          lock_s;

   assign lock_s = sync_q[1];

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      pll_resetb_d   = pll_resetb_q;
      rst_core_n_d   = rst_core_n_q;
      rst_periph_n_d = rst_periph_n_q;
      lock_loss_d    = lock_loss_q;
      retry_d        = retry_q;
      case (state_q)
         PLL_RST: begin
            if (cnt_q == CW'(PLL_RST_CYCLES - 1)) begin
               state_d      = WAIT_LOCK;
               cnt_d        = '0;
               pll_resetb_d = 1'b1;
            end else cnt_d = cnt_q + CW'(1);
         end
         WAIT_LOCK: begin
            if (lock_s) begin
               state_d = STABLE;
               cnt_d   = '0;
            end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
               state_d      = PLL_RST;
               cnt_d        = '0;
               pll_resetb_d = 1'b0;
               retry_d      = retry_q + 8'(retry_q != 8'hff);
            end else cnt_d = cnt_q + CW'(1);
         end
         STABLE: begin
            if (!lock_s) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
               state_d      = RELEASE;
               cnt_d        = '0;
               rst_core_n_d = 1'b1;
            end else cnt_d = cnt_q + CW'(1);
         end
         RELEASE, RUN: begin
            // Loss takes priority over a stage delay completing on the same edge
            if (!lock_s) begin
               state_d        = WAIT_LOCK;
               cnt_d          = '0;
               rst_core_n_d   = 1'b0;
               rst_periph_n_d = 1'b0;
               lock_loss_d    = lock_loss_q + 8'(lock_loss_q != 8'hff);
            end else if (state_q == RELEASE && cnt_q == CW'(STAGE_DELAY - 1)) begin
               state_d        = RUN;
               cnt_d          = '0;
               rst_periph_n_d = 1'b1;
            end else if (state_q == RELEASE) cnt_d = cnt_q + CW'(1);
         end
         default: state_d = PLL_RST;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= PLL_RST;
         cnt_q          <= '0;
         sync_q         <= '0;
         pll_resetb_q   <= 1'b0;
         rst_core_n_q   <= 1'b0;
         rst_periph_n_q <= 1'b0;
         lock_loss_q    <= '0;
         retry_q        <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         sync_q         <= {sync_q[0], lock};
         pll_resetb_q   <= pll_resetb_d;
         rst_core_n_q   <= rst_core_n_d;
         rst_periph_n_q <= rst_periph_n_d;
         lock_loss_q    <= lock_loss_d;
         retry_q        <= retry_d;
      end
   end

   assign pll_resetb      = pll_resetb_q;
   assign rst_core_n      = rst_core_n_q;
   assign rst_periph_n    = rst_periph_n_q;
   assign ready           = rst_periph_n_q;
   assign lock_loss_count = lock_loss_q;
   assign retry_count     = retry_q;
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: scenario tasks push expected output snapshots per cycle and compare
// them as the cycle is reached; cycle 1 is the first clock edge after reset_n deasserts.
module tb_pll_reset_sequencer;
   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       lock = 1'b0;
   logic       pll_resetb, rst_core_n, rst_periph_n, ready;
   logic [7:0] lock_loss_count, retry_count;
   logic [19:0] obs;

   typedef struct {
      int         cyc;
      logic [3:0] o;
      logic [7:0] loss;
      logic [7:0] retry;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   vectors = 0;
   int   miscompares = 0;

   assign obs = {pll_resetb, rst_core_n, rst_periph_n, ready, lock_loss_count, retry_count};

   always #5 clock = ~clock;

   pll_reset_sequencer #(
      .PLL_RST_CYCLES(4),
      .LOCK_TIMEOUT(32),
      .STABLE_CYCLES(8),
      .STAGE_DELAY(4)
   ) dut (
      .clock(clock),
      .reset_n(reset_n),
      .lock(lock),
      .pll_resetb(pll_resetb),
      .rst_core_n(rst_core_n),
      .rst_periph_n(rst_periph_n),
      .ready(ready),
      .lock_loss_count(lock_loss_count),
      .retry_count(retry_count)
   );

   function automatic void push(int cyc, logic [3:0] o, logic [7:0] loss, logic [7:0] retry);
      exp_t x;
      x.cyc = cyc;
      x.o = o;
      x.loss = loss;
      x.retry = retry;
      sb.push_back(x);
   endfunction

   task automatic do_reset();
      reset_n = 1'b0;
      lock = 1'b0;
      repeat (2) @(posedge clock);
      #3 reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      lock = 1'b1;
      repeat (3) @(posedge clock);
      #1 vectors++;
      if (obs !== 20'h0) begin
         miscompares++;
         $display("FAIL reset got=%h exp=%h", obs, 20'h0);
      end
   endtask

   task automatic test_nominal();
      do_reset();
      push(3, 4'b0000, 0, 0); push(4, 4'b1000, 0, 0); push(19, 4'b1000, 0, 0);
      push(20, 4'b1100, 0, 0); push(23, 4'b1100, 0, 0); push(24, 4'b1111, 0, 0);
      push(30, 4'b1111, 0, 0);
      for (int c = 1; c <= 30; c++) begin
         lock = (c >= 10);
         @(posedge clock);
         #1 while (sb.size() != 0 && sb[0].cyc == c) begin
            e = sb.pop_front();
            vectors++;
            if (obs !== {e.o, e.loss, e.retry}) begin
               miscompares++;
               $display("FAIL nominal c=%0d got=%h exp=%h", c, obs, {e.o, e.loss, e.retry});
            end
         end
      end
   endtask

   task automatic test_loss_in_run();
      push(2, 4'b1111, 0, 0); push(3, 4'b1000, 1, 0); push(14, 4'b1000, 1, 0);
      push(15, 4'b1100, 1, 0); push(18, 4'b1100, 1, 0); push(19, 4'b1111, 1, 0);
      for (int c = 1; c <= 20; c++) begin
         lock = (c >= 5);
         @(posedge clock);
         #1 while (sb.size() != 0 && sb[0].cyc == c) begin
            e = sb.pop_front();
            vectors++;
            if (obs !== {e.o, e.loss, e.retry}) begin
               miscompares++;
               $display("FAIL loss_in_run c=%0d got=%h exp=%h", c, obs, {e.o, e.loss, e.retry});
            end
         end
      end
   endtask

   task automatic test_glitch();
      do_reset();
      push(17, 4'b1000, 0, 0); push(25, 4'b1000, 0, 0); push(26, 4'b1100, 0, 0);
      push(29, 4'b1100, 0, 0); push(30, 4'b1111, 0, 0);
      for (int c = 1; c <= 31; c++) begin
         lock = (c >= 10 && c != 15);
         @(posedge clock);
         #1 while (sb.size() != 0 && sb[0].cyc == c) begin
            e = sb.pop_front();
            vectors++;
            if (obs !== {e.o, e.loss, e.retry}) begin
               miscompares++;
               $display("FAIL glitch c=%0d got=%h exp=%h", c, obs, {e.o, e.loss, e.retry});
            end
         end
      end
   endtask

   task automatic test_race();
      do_reset();
      push(20, 4'b1000, 0, 0); push(28, 4'b1000, 0, 0); push(29, 4'b1100, 0, 0);
      push(32, 4'b1100, 0, 0); push(33, 4'b1000, 1, 0); push(40, 4'b1000, 1, 0);
      for (int c = 1; c <= 40; c++) begin
         lock = (c >= 10 && c != 18 && c < 31);
         @(posedge clock);
         #1 while (sb.size() != 0 && sb[0].cyc == c) begin
            e = sb.pop_front();
            vectors++;
            if (obs !== {e.o, e.loss, e.retry}) begin
               miscompares++;
               $display("FAIL race c=%0d got=%h exp=%h", c, obs, {e.o, e.loss, e.retry});
            end
         end
      end
   endtask

   task automatic test_timeout();
      do_reset();
      push(35, 4'b1000, 0, 0); push(36, 4'b0000, 0, 1); push(39, 4'b0000, 0, 1);
      push(40, 4'b1000, 0, 1); push(71, 4'b1000, 0, 1); push(72, 4'b0000, 0, 2);
      push(9179, 4'b1000, 0, 254); push(9180, 4'b0000, 0, 255); push(9216, 4'b0000, 0, 255);
      for (int c = 1; c <= 9217; c++) begin
         lock = 1'b0;
         @(posedge clock);
         #1 while (sb.size() != 0 && sb[0].cyc == c) begin
            e = sb.pop_front();
            vectors++;
            if (obs !== {e.o, e.loss, e.retry}) begin
               miscompares++;
               $display("FAIL timeout c=%0d got=%h exp=%h", c, obs, {e.o, e.loss, e.retry});
            end
         end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      push(40, 4'b1000, 0, 1); push(48, 4'b1000, 0, 1); push(49, 4'b1100, 0, 1);
      push(51, 4'b1100, 0, 1);
      for (int c = 1; c <= 51; c++) begin
         lock = (c >= 38);
         @(posedge clock);
         #1 while (sb.size() != 0 && sb[0].cyc == c) begin
            e = sb.pop_front();
            vectors++;
            if (obs !== {e.o, e.loss, e.retry}) begin
               miscompares++;
               $display("FAIL async_pre c=%0d got=%h exp=%h", c, obs, {e.o, e.loss, e.retry});
            end
         end
      end
      #2 reset_n = 1'b0;
      #1 vectors++;
      if (obs !== 20'h0) begin
         miscompares++;
         $display("FAIL async_reset got=%h exp=%h", obs, 20'h0);
      end
      @(posedge clock);
      #3 reset_n = 1'b1;
      push(3, 4'b0000, 0, 0); push(4, 4'b1000, 0, 0); push(12, 4'b1000, 0, 0);
      push(13, 4'b1100, 0, 0); push(16, 4'b1100, 0, 0); push(17, 4'b1111, 0, 0);
      for (int c = 1; c <= 18; c++) begin
         lock = 1'b1;
         @(posedge clock);
         #1 while (sb.size() != 0 && sb[0].cyc == c) begin
            e = sb.pop_front();
            vectors++;
            if (obs !== {e.o, e.loss, e.retry}) begin
               miscompares++;
               $display("FAIL async_post c=%0d got=%h exp=%h", c, obs, {e.o, e.loss, e.retry});
            end
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_nominal();
      test_loss_in_run();
      test_glitch();
      test_race();
      test_timeout();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
